// File: rtl/rr_priority_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_arbiter_pkg
// Description : Shared definitions for the round-robin / fixed-priority
//               arbiter: FSM state encoding, a constant-evaluable clog2
//               and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_priority_arbiter_pkg;

    // Widest vector the one-hot helper can produce; callers cast down to N.
    localparam int c_MAX_N = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2, usable in parameter expressions. clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // One-hot decode of a binary index into a c_MAX_N-bit vector.
    function automatic logic [c_MAX_N-1:0] onehot(input logic [4:0] idx);
        logic [c_MAX_N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage : rr_priority_arbiter_pkg
`default_nettype wire

// File: rtl/rr_prio_scan.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_scan
// Description : Combinational priority scan. Finds the first set request
//               bit when scanning downward from 'start' with wrap-around:
//               start, start-1, ..., 0, N-1, ..., start+1.
//               Implemented as rotate -> priority-encode -> unrotate.
// Ports       : req    [N]      request vector
//               start  [IDX_W]  index holding highest priority
//               found  [1]      at least one request set
//               winner [IDX_W]  index of the winning requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_scan
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    // Modulo-N wrap; works for non power-of-two N as well.
    function automatic logic [IDX_W-1:0] wrap_idx(input int value);
        return IDX_W'(value % N);
    endfunction

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_top;

    // Rotate so that req[start] lands on the top bit (N-1); bit k of the
    // rotated vector then holds req[(k + start + 1) mod N].
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < N; k++) begin
            w_rot[k] = req[wrap_idx(k + int'(start) + 1)];
        end
    end

    // Highest set bit of the rotated vector wins.
    always_comb begin
        w_top = '0;
        for (int k = 0; k < N; k++) begin
            if (w_rot[k]) begin
                w_top = IDX_W'(k);
            end
        end
    end

    assign found  = |req;
    assign winner = wrap_idx(int'(w_top) + int'(start) + 1);

endmodule : rr_prio_scan
`default_nettype wire

// File: rtl/rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_arbiter
// Description : N-requester arbiter with registered one-hot grant.
//               Run-time selectable fixed priority (index N-1 highest) or
//               round-robin. A winner keeps the grant while it requests,
//               bounded by MAX_HOLD consecutive cycles (0 = unlimited).
//               Every release is followed by one idle cycle.
// Ports       : clk        clock, posedge
//               rst        synchronous active-high reset
//               mode_rr    1 = round-robin, 0 = fixed priority
//               req   [N]  request vector
//               gnt   [N]  one-hot grant (registered)
//               gnt_idx    binary index of granted requester (registered)
//               gnt_valid  grant active (registered, equals |gnt)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDX_W    = clog2(N),
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_rr,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int HOLD_W = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1);

    localparam logic [IDX_W-1:0]  c_TOP_IDX   = IDX_W'(N - 1);
    // Last hold_cnt value at which the grant may still be extended.
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q,     state_d;
    logic [N-1:0]      gnt_q,       gnt_d;
    logic [IDX_W-1:0]  gnt_idx_q,   gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]  ptr_q,       ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    // Mode captured at arbitration; the pointer update on release follows
    // the mode the grant was won under, so a mid-grant toggle has no effect.
    logic              mode_q,      mode_d;

    logic [IDX_W-1:0]  w_scan_start;
    logic              w_scan_found;
    logic [IDX_W-1:0]  w_scan_winner;
    logic              w_hold;

    assign w_scan_start = mode_rr ? ptr_q : c_TOP_IDX;

    rr_prio_scan #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_scan (
        .req    (req),
        .start  (w_scan_start),
        .found  (w_scan_found),
        .winner (w_scan_winner)
    );

    assign w_hold = req[gnt_idx_q] && ((MAX_HOLD == 0) || (hold_cnt_q < c_HOLD_LAST));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        mode_d      = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (w_scan_found) begin
                    gnt_d       = N'(onehot(5'(w_scan_winner)));
                    gnt_idx_d   = w_scan_winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    mode_d      = mode_rr;
                    state_d     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (w_hold) begin
                    // Saturates only matters for the unlimited case.
                    if (hold_cnt_q != '1) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    // Round-robin: the releasing requester becomes lowest priority.
                    if (mode_q) begin
                        ptr_d = (gnt_idx_q == '0) ? c_TOP_IDX : gnt_idx_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= c_TOP_IDX;
            hold_cnt_q  <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            mode_q      <= mode_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule : rr_priority_arbiter
`default_nettype wire
